// File: rtl/sub_shift_rows_if.sv
// Handshake bus for the sub_shift_rows stage: state in, permuted/substituted state out.
// With SSR_INVERSE_EN defined the bus also carries the per-operation inverse select.
interface sub_shift_rows_if;
  localparam int unsigned DATA_W = 128;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
`ifdef SSR_INVERSE_EN
  logic              inverse;

  modport master (output in_valid, data_in, out_ready, inverse,
                  input  in_ready, out_valid, data_out);
  modport slave  (input  in_valid, data_in, out_ready, inverse,
                  output in_ready, out_valid, data_out);
`else
  modport master (output in_valid, data_in, out_ready,
                  input  in_ready, out_valid, data_out);
  modport slave  (input  in_valid, data_in, out_ready,
                  output in_ready, out_valid, data_out);
`endif
endinterface

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows stage, SBOX_PER_CYCLE bytes substituted per clock.
// Optional macro SSR_INVERSE_EN adds an inverse select (InvSubBytes + InvShiftRows).
module sub_shift_rows #(
  parameter int unsigned SBOX_PER_CYCLE = 4
) (
  input logic             clk,
  input logic             n_rst,
  sub_shift_rows_if.slave bus
);
  localparam int unsigned NCHUNK = 16 / SBOX_PER_CYCLE;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CW     = 8 * SBOX_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  localparam logic [0:255][7:0] SBOX_LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] s_box(input logic [7:0] a);
    return SBOX_LUT[a];
  endfunction

`ifdef SSR_INVERSE_EN
  localparam logic [0:255][7:0] INV_SBOX_LUT = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_s_box(input logic [7:0] a);
    return INV_SBOX_LUT[a];
  endfunction

  logic inv_q;
`endif

  typedef enum logic [1:0] {IDLE, SUB, DONE} fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     state_q;
  logic             out_valid_q;
  logic [CW-1:0]    chunk_in;
  logic [CW-1:0]    chunk_out;
  logic [127:0]     sub_state;
  logic [127:0]     shifted;
  logic             accept;

  assign bus.in_ready  = (fsm == IDLE) | ((fsm == DONE) & bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = shifted;
  assign accept        = bus.in_valid & bus.in_ready;

  // Select the chunk of bytes being substituted this cycle.
  always_comb begin
    chunk_in = '0;
    for (int k = 0; k < int'(NCHUNK); k++) begin
      if (cnt == CNT_W'(k)) chunk_in = state_q[k*CW +: CW];
    end
  end

  for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_lane
`ifdef SSR_INVERSE_EN
    assign chunk_out[8*j +: 8] = inv_q ? inv_s_box(chunk_in[8*j +: 8])
                                       : s_box(chunk_in[8*j +: 8]);
`else
    assign chunk_out[8*j +: 8] = s_box(chunk_in[8*j +: 8]);
`endif
  end

  // Write the substituted chunk back in place.
  always_comb begin
    sub_state = state_q;
    for (int k = 0; k < int'(NCHUNK); k++) begin
      if (cnt == CNT_W'(k)) sub_state[k*CW +: CW] = chunk_out;
    end
  end

  // Row permutation is pure wiring; row r rotates left by r (right by r when inverse).
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
`ifdef SSR_INVERSE_EN
        if (inv_q)
          shifted[32*c + 8*(3-r) +: 8] = state_q[32*((c + 4 - r) % 4) + 8*(3-r) +: 8];
        else
          shifted[32*c + 8*(3-r) +: 8] = state_q[32*((c + r) % 4) + 8*(3-r) +: 8];
`else
        shifted[32*c + 8*(3-r) +: 8] = state_q[32*((c + r) % 4) + 8*(3-r) +: 8];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm         <= IDLE;
      cnt         <= '0;
      state_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef SSR_INVERSE_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            state_q <= bus.data_in;
            cnt     <= '0;
            fsm     <= SUB;
`ifdef SSR_INVERSE_EN
            inv_q   <= bus.inverse;
`endif
          end
        end
        SUB: begin
          state_q <= sub_state;
          if (cnt == LAST) begin
            cnt         <= '0;
            fsm         <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Retire on out_ready; a simultaneous in_valid starts the next state back-to-back.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              state_q <= bus.data_in;
              cnt     <= '0;
              fsm     <= SUB;
`ifdef SSR_INVERSE_EN
              inv_q   <= bus.inverse;
`endif
            end else begin
              fsm <= IDLE;
            end
          end
        end
        default: begin
          fsm         <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_shift_rows.sv
// Bench for sub_shift_rows: directed vectors, random traffic against a GF(2^8) reference,
// backpressure, async reset and a parameter sweep of SBOX_PER_CYCLE.
module tb_sub_shift_rows;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  sub_shift_rows_if bus();
  sub_shift_rows #(.SBOX_PER_CYCLE(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  // Sweep instances share one stimulus so their latencies can be compared side by side.
  localparam int SW_P   [4] = '{1, 2, 8, 16};
  localparam int SW_LAT [4] = '{16, 8, 2, 1};
  logic         sw_in_valid;
  logic         sw_out_ready;
  logic [127:0] sw_data_in;
  logic [3:0]   sw_out_valid;
  logic [127:0] sw_data_out [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    sub_shift_rows_if sif();
    assign sif.in_valid    = sw_in_valid;
    assign sif.data_in     = sw_data_in;
    assign sif.out_ready   = sw_out_ready;
`ifdef SSR_INVERSE_EN
    assign sif.inverse     = 1'b0;
`endif
    assign sw_out_valid[g] = sif.out_valid;
    assign sw_data_out[g]  = sif.data_out;
    sub_shift_rows #(.SBOX_PER_CYCLE(SW_P[g])) u_dut (.clk(clk), .n_rst(n_rst), .bus(sif));
  end

  localparam logic [127:0] FIPS_IN  = 128'he9f84808_9ac68d2a_a0f4e22b_193de3be;
  localparam logic [127:0] FIPS_OUT = 128'h1e2798e5_b84111f1_e0b452ae_d4bf5d30;
  localparam logic [127:0] ZERO_OUT = 128'h63636363_63636363_63636363_63636363;

  // Reference S-box derived from the field inverse and affine map, not a stored table.
  logic [7:0] ref_s   [256];
  logic [7:0] ref_inv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] y;
    y = b;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    int src;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        y[32*c + 8*(3-r) +: 8] = inv ? ref_inv[x[32*src + 8*(3-r) +: 8]]
                                     : ref_s[x[32*src + 8*(3-r) +: 8]];
      end
    end
    return y;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inverse(input bit inv);
`ifdef SSR_INVERSE_EN
    bus.inverse = inv;
`else
    if (inv) $display("inverse request ignored in forward-only build");
`endif
  endtask

  // Wait for out_valid after an accept edge, poking ignored traffic meanwhile.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.data_in  = {4{$urandom}};
      set_inverse(1'($urandom_range(0, 1)));
      #1;
      check({tag, "_busy_in_ready"}, 128'(bus.in_ready), 128'(1'b0));
      step();
      lat++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_and_check(input logic [127:0] d, input bit inv,
                                input logic [127:0] exp, input string tag);
    int lat;
    int hold;
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    bus.out_ready = 1'b0;
    set_inverse(inv);
    #1;
    check({tag, "_idle_in_ready"}, 128'(bus.in_ready), 128'(1'b1));
    step();
    wait_valid(tag, lat);
    check({tag, "_latency"}, 128'(lat), 128'(4));
    check({tag, "_data"}, bus.data_out, exp);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_data"}, bus.data_out, exp);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_retired"}, 128'(bus.out_valid), 128'(1'b0));
  endtask

  task automatic sweep(input logic [127:0] d, input logic [127:0] exp, input string tag);
    int lat [4];
    sw_in_valid  = 1'b1;
    sw_data_in   = d;
    sw_out_ready = 1'b0;
    step();
    sw_in_valid = 1'b0;
    for (int g = 0; g < 4; g++) lat[g] = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      step();
      for (int g = 0; g < 4; g++) if (sw_out_valid[g] && lat[g] == 0) lat[g] = cyc;
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s_p%0d_latency", tag, SW_P[g]), 128'(lat[g]), 128'(SW_LAT[g]));
      check($sformatf("%s_p%0d_data", tag, SW_P[g]), sw_data_out[g], exp);
    end
    sw_out_ready = 1'b1;
    step();
    sw_out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] d2;
    int lat;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'h01;
      for (int e = 0; e < 254; e++) b = gmul(b, 8'(i));
      ref_s[i] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) ref_inv[ref_s[i]] = 8'(i);

    n_rst         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    set_inverse(1'b0);
    sw_in_valid   = 1'b0;
    sw_out_ready  = 1'b0;
    sw_data_in    = '0;
    step();
    step();
    check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("rst_data_out", bus.data_out, 128'h0);
    n_rst = 1'b1;
    step();

    // Async reset while substituting.
    bus.in_valid = 1'b1;
    bus.data_in  = {4{$urandom}};
    step();
    bus.in_valid = 1'b0;
    step();
    check("midsub_in_ready_low", 128'(bus.in_ready), 128'(1'b0));
    n_rst = 1'b0;
    #1;
    check("midsub_rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("midsub_rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("midsub_rst_data_out", bus.data_out, 128'h0);
    #2 n_rst = 1'b1;
    step();
    send_and_check(128'h0, 1'b0, ZERO_OUT, "zero");
    send_and_check(FIPS_IN, 1'b0, FIPS_OUT, "fips");

    // Async reset while holding a completed result.
    bus.in_valid = 1'b1;
    bus.data_in  = FIPS_IN;
    step();
    bus.in_valid = 1'b0;
    wait_valid("middone", lat);
    check("middone_valid", 128'(bus.out_valid), 128'(1'b1));
    n_rst = 1'b0;
    #1;
    check("middone_rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("middone_rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    #2 n_rst = 1'b1;
    step();

    // Backpressure then back-to-back accept in the retiring cycle.
    bus.in_valid = 1'b1;
    bus.data_in  = FIPS_IN;
    step();
    bus.in_valid = 1'b0;
    wait_valid("bp", lat);
    check("bp_latency", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_data", bus.data_out, FIPS_OUT);
      check("bp_hold_in_ready", 128'(bus.in_ready), 128'(1'b0));
      check("bp_hold_valid", 128'(bus.out_valid), 128'(1'b1));
    end
    d2 = {4{$urandom}};
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = d2;
    #1;
    check("b2b_in_ready", 128'(bus.in_ready), 128'(1'b1));
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("b2b_valid_drop", 128'(bus.out_valid), 128'(1'b0));
    wait_valid("b2b", lat);
    check("b2b_latency", 128'(lat), 128'(4));
    check("b2b_data", bus.data_out, ref_model(d2, 1'b0));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    for (int n = 0; n < 12; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_and_check(d, 1'b0, ref_model(d, 1'b0), $sformatf("rand%0d", n));
    end

    sweep(FIPS_IN, FIPS_OUT, "sweep_fips");
    d = {$urandom, $urandom, $urandom, $urandom};
    sweep(d, ref_model(d, 1'b0), "sweep_rand");

`ifdef SSR_INVERSE_EN
    send_and_check(FIPS_OUT, 1'b1, FIPS_IN, "inv_fips");
    for (int n = 0; n < 6; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_and_check(d, 1'b1, ref_model(d, 1'b1), $sformatf("inv_rand%0d", n));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
